e_mdu: RTL and testbench

- Multiply/divide unit in the E stage, in parallel with the ALU.
- Takes the same forwarded operands A/B and owns the architectural HI/LO registers.
- Its MDUOut feeds the E-stage result mux beside the ALU result AO.
- Busy feeds the hazard unit, which stalls any MDU instruction in D while a multi-cycle operation is in flight.

---
 rtl/e_mdu.sv | 109 ++++++++++
 tb/tb_e_mdu.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/e_mdu.sv
`default_nettype none
// ============================================================================
// Module   : e_mdu
// Purpose  : E-stage multiply/divide unit with architectural HI/LO registers,
//            fixed-latency multi-cycle MULT/DIV and single-cycle MT/MF access.
// Revision : 1.0  initial release
// ============================================================================
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDUOp,
  input  logic        Start,
  input  logic        Req,
  output logic        Busy,
  output logic [31:0] MDUOut,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] c_OP_MULT  = 4'd1;
  localparam logic [3:0] c_OP_MULTU = 4'd2;
  localparam logic [3:0] c_OP_DIV   = 4'd3;
  localparam logic [3:0] c_OP_DIVU  = 4'd4;
  localparam logic [3:0] c_OP_MFHI  = 4'd5;
  localparam logic [3:0] c_OP_MFLO  = 4'd6;
  localparam logic [3:0] c_OP_MTHI  = 4'd7;
  localparam logic [3:0] c_OP_MTLO  = 4'd8;

  localparam int unsigned c_MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned c_CW   = $clog2(c_MAXC + 1);

  logic [c_CW-1:0] r_cnt;
  logic [31:0]     r_hi, r_lo, r_hi_t, r_lo_t;

  logic               w_accept, w_mthi, w_mtlo, w_is_mul, w_b_zero;
  logic signed [63:0] w_smul;
  logic [63:0]        w_umul;
  logic [31:0]        w_a_abs, w_b_abs, w_b_safe, w_uq, w_ur, w_sq_mag, w_sr_mag;
  logic [31:0]        w_sq, w_sr, w_hi_n, w_lo_n;

  assign Busy     = (r_cnt != '0);
  assign w_accept = Start && !Req && !Busy && (MDUOp >= c_OP_MULT) && (MDUOp <= c_OP_DIVU);
  assign w_mthi   = !Req && !Busy && (MDUOp == c_OP_MTHI);
  assign w_mtlo   = !Req && !Busy && (MDUOp == c_OP_MTLO);
  assign w_is_mul = (MDUOp == c_OP_MULT) || (MDUOp == c_OP_MULTU);
  assign w_b_zero = (B == 32'd0);

  assign w_smul = $signed(A) * $signed(B);
  assign w_umul = {32'd0, A} * {32'd0, B};

  // Signed divide done on magnitudes so INT_MIN / -1 wraps to INT_MIN cleanly.
  assign w_a_abs  = A[31] ? (32'd0 - A) : A;
  assign w_b_abs  = B[31] ? (32'd0 - B) : B;
  assign w_b_safe = w_b_zero ? 32'd1 : B;
  assign w_uq     = A / w_b_safe;
  assign w_ur     = A % w_b_safe;
  assign w_sq_mag = w_a_abs / (w_b_zero ? 32'd1 : w_b_abs);
  assign w_sr_mag = w_a_abs % (w_b_zero ? 32'd1 : w_b_abs);
  assign w_sq     = (A[31] ^ B[31]) ? (32'd0 - w_sq_mag) : w_sq_mag;
  assign w_sr     = A[31] ? (32'd0 - w_sr_mag) : w_sr_mag;

  always_comb begin
    w_hi_n = r_hi;
    w_lo_n = r_lo;
    case (MDUOp)
      c_OP_MULT:  begin w_hi_n = w_smul[63:32]; w_lo_n = w_smul[31:0]; end
      c_OP_MULTU: begin w_hi_n = w_umul[63:32]; w_lo_n = w_umul[31:0]; end
      c_OP_DIV:   if (!w_b_zero) begin w_hi_n = w_sr; w_lo_n = w_sq; end
      c_OP_DIVU:  if (!w_b_zero) begin w_hi_n = w_ur; w_lo_n = w_uq; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_hi   <= 32'd0;
      r_lo   <= 32'd0;
      r_hi_t <= 32'd0;
      r_lo_t <= 32'd0;
    end else begin
      if (w_accept) begin
        r_hi_t <= w_hi_n;
        r_lo_t <= w_lo_n;
        r_cnt  <= w_is_mul ? c_CW'(MULT_CYCLES) : c_CW'(DIV_CYCLES);
      end else if (Busy) begin
        r_cnt <= r_cnt - c_CW'(1);
        if (r_cnt == c_CW'(1)) begin
          r_hi <= r_hi_t;
          r_lo <= r_lo_t;
        end
      end
      if (w_mthi) r_hi <= A;
      if (w_mtlo) r_lo <= A;
    end
  end

  assign HI = r_hi;
  assign LO = r_lo;
  assign MDUOut = (MDUOp == c_OP_MFHI) ? r_hi :
                  (MDUOp == c_OP_MFLO) ? r_lo : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_e_mdu.sv
`default_nettype none
// ============================================================================
// Module   : tb_e_mdu
// Purpose  : Directed self-checking bench for e_mdu with hand-computed vectors.
// Revision : 1.0  initial release
// ============================================================================
module tb_e_mdu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic [3:0]  MDUOp = 4'd0;
  logic        Start = 1'b0;
  logic        Req = 1'b0;
  logic        Busy;
  logic [31:0] MDUOut, HI, LO;

  int vecs = 0;
  int errs = 0;
  int n;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MDUOp(MDUOp), .Start(Start),
    .Req(Req), .Busy(Busy), .MDUOut(MDUOut), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue a multi-cycle op, then count cycles with Busy high (bounded).
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cycles);
    MDUOp = op; A = a; B = b; Start = 1'b1; Req = 1'b0;
    tick();
    MDUOp = 4'd0; Start = 1'b0; A = 32'd0; B = 32'd0;
    cycles = 0;
    while (Busy && cycles < 100) begin
      cycles++;
      tick();
    end
  endtask

  initial begin
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_out", MDUOut, 32'd0);

    run_op(4'd1, 32'hFFFFFFFF, 32'd2, n);
    chk("mult_cyc", n, 32'd5);
    chk("mult_hi", HI, 32'hFFFFFFFF);
    chk("mult_lo", LO, 32'hFFFFFFFE);

    run_op(4'd2, 32'hFFFFFFFF, 32'd2, n);
    chk("multu_cyc", n, 32'd5);
    chk("multu_hi", HI, 32'h00000001);
    chk("multu_lo", LO, 32'hFFFFFFFE);

    run_op(4'd1, 32'hFFFFFFFD, 32'hFFFFFFF9, n);  // -3 * -7 = 21
    chk("mult_nn_hi", HI, 32'h00000000);
    chk("mult_nn_lo", LO, 32'd21);

    run_op(4'd3, 32'hFFFFFFF9, 32'd2, n);
    chk("div_cyc", n, 32'd10);
    chk("div_lo", LO, 32'hFFFFFFFD);
    chk("div_hi", HI, 32'hFFFFFFFF);

    run_op(4'd4, 32'hFFFFFFF9, 32'd2, n);
    chk("divu_lo", LO, 32'h7FFFFFFC);
    chk("divu_hi", HI, 32'h00000001);

    run_op(4'd3, 32'd7, 32'hFFFFFFFE, n);  // 7 / -2 = -3 rem 1
    chk("div_nd_lo", LO, 32'hFFFFFFFD);
    chk("div_nd_hi", HI, 32'h00000001);

    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, n);
    chk("div_ovf_lo", LO, 32'h80000000);
    chk("div_ovf_hi", HI, 32'h00000000);

    // Divide by zero keeps HI/LO
    reset = 1'b1; tick(); reset = 1'b0;
    MDUOp = 4'd7; A = 32'h12345678; tick();
    MDUOp = 4'd0; A = 32'd0;
    chk("mthi", HI, 32'h12345678);
    run_op(4'd4, 32'd7, 32'd0, n);
    chk("div0_cyc", n, 32'd10);
    chk("div0_hi", HI, 32'h12345678);
    chk("div0_lo", LO, 32'h00000000);
    MDUOp = 4'd5; #1;
    chk("mfhi", MDUOut, 32'h12345678);
    MDUOp = 4'd6; #1;
    chk("mflo", MDUOut, 32'h00000000);
    MDUOp = 4'd9; #1;
    chk("mf_other", MDUOut, 32'h00000000);

    // Req suppresses Start and MT
    MDUOp = 4'd1; A = 32'd3; B = 32'd4; Start = 1'b1; Req = 1'b1;
    tick();
    chk("req_busy", {31'd0, Busy}, 32'd0);
    Start = 1'b0; MDUOp = 4'd8; A = 32'hDEADBEEF;
    tick();
    chk("req_hi", HI, 32'h12345678);
    chk("req_lo", LO, 32'h00000000);
    Req = 1'b0; MDUOp = 4'd8; A = 32'hCAFEF00D;
    tick();
    chk("mtlo", LO, 32'hCAFEF00D);

    // Start while busy is ignored; original commits on time
    MDUOp = 4'd1; A = 32'd3; B = 32'd4; Start = 1'b1;
    tick();
    Start = 1'b0; MDUOp = 4'd0;
    chk("ovl_c1", {31'd0, Busy}, 32'd1);
    tick();
    MDUOp = 4'd3; A = 32'd100; B = 32'd5; Start = 1'b1; Req = 1'b1;
    tick();
    Req = 1'b0;
    tick();
    Start = 1'b0; MDUOp = 4'd8; A = 32'h55555555;  // MTLO while busy: ignored
    chk("ovl_c4_busy", {31'd0, Busy}, 32'd1);
    chk("ovl_c4_hi", HI, 32'h12345678);
    tick();
    MDUOp = 4'd0;
    chk("ovl_c5_busy", {31'd0, Busy}, 32'd1);
    chk("ovl_c5_lo", LO, 32'hCAFEF00D);
    tick();
    chk("ovl_done_busy", {31'd0, Busy}, 32'd0);
    chk("ovl_hi", HI, 32'd0);
    chk("ovl_lo", LO, 32'd12);
    tick();
    chk("ovl_after_busy", {31'd0, Busy}, 32'd0);
    chk("ovl_after_lo", LO, 32'd12);

    // Reset mid-DIV aborts without commit
    MDUOp = 4'd3; A = 32'd100; B = 32'd7; Start = 1'b1;
    tick();
    Start = 1'b0; MDUOp = 4'd0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", {31'd0, Busy}, 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    for (int i = 0; i < 12; i++) tick();
    chk("abort_late_lo", LO, 32'd0);
    chk("abort_late_hi", HI, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
